vc_input_buffer_bank: RTL
=========================

Name: vc_input_buffer_bank

Overview:
Multi-VC input-port buffer bank: VC_NUM independent flit FIFOs, each with its own IDLE/VA/SA packet state machine. Sits between the link receiver and the VC/switch allocators of one router input port. Generalises the single-VC input buffer with:
- a parametrised VC count
- demux on the incoming flit vc_id
- per-VC credit return
- occupancy-based on/off flow control
- write-while-full protection

Parameters:
VC_NUM, 2, number of virtual channels (>=1); must equal 2**VC_SIZE from noc_params.
BUFFER_SIZE, 8, flit slots per VC (power of two, >=2).
OFF_THRESH, 2, on_off_o[v] drops when free slots of VC v <= OFF_THRESH (must be < BUFFER_SIZE).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
data_i  in  flit_t  incoming flit; vc_id selects target VC
valid_i  in  1  data_i valid this cycle
out_port_i  in  port_t  route for the flit on data_i (meaningful for heads only)
read_i  in  VC_NUM  per-VC pop strobe from switch traversal
vc_valid_i  in  VC_NUM  per-VC downstream VC grant
vc_new_i  in  VC_NUM x VC_SIZE  granted downstream VC id per VC
data_o  out  VC_NUM x flit_t  head flit per VC; vc_id field = latched downstream VC
out_port_o  out  VC_NUM x port_t  latched route per VC
downstream_vc_o  out  VC_NUM x VC_SIZE  latched downstream VC per VC
vc_request_o  out  VC_NUM  VC allocation request
switch_request_o  out  VC_NUM  switch allocation request
vc_allocatable_o  out  VC_NUM  one-cycle pulse: VC released
credit_o  out  VC_NUM  one-cycle credit pulse per popped flit
is_empty_o  out  VC_NUM  FIFO empty
is_full_o  out  VC_NUM  FIFO full
on_off_o  out  VC_NUM  1 = upstream may send to VC v
error_o  out  VC_NUM  protocol error indication

Behaviour:
Reset (clk edge with rst=1):
- All FSMs go to IDLE; FIFOs emptied; count = 0.
- out_port_o = DLA0; downstream_vc_o = 0.
- vc_request_o, switch_request_o, vc_allocatable_o, credit_o, error_o all = 0.
- is_empty_o = all 1; is_full_o = 0; on_off_o = all 1.
- Reset asserted mid-packet discards all buffered flits silently; no credits are issued for them.

Write demux:
- Only VC v = data_i.vc_id is considered when valid_i = 1.
- A write is accepted if the per-state rules below allow it AND (count < BUFFER_SIZE OR read_i[v] is popped the same cycle).
- A write while full with no pop is dropped and sets error.
- Accepted flit appears in data_o[v] / is_empty_o[v] = 0 the cycle after the write edge when the FIFO was empty.
- Pointers wrap modulo BUFFER_SIZE.
- count is (log2 BUFFER_SIZE)+1 bits; a simultaneous read and write leaves count unchanged.

Per-VC FSM:
- IDLE:
  - Head write (label HEAD or HEADTAIL) with empty FIFO -> VA; latch out_port_i.
  - HEADTAIL also sets end_packet.
  - Error on: BODY/TAIL write, read_i[v], vc_valid_i[v], or non-empty FIFO.
- VA:
  - vc_request_o[v] = 1 (combinational).
  - On vc_valid_i[v] -> SA; latch vc_new_i[v].
  - BODY/TAIL writes accepted while end_packet = 0; TAIL sets end_packet.
  - Error on: HEAD/HEADTAIL write, any write after end_packet, or read_i[v].
- SA:
  - switch_request_o[v] = ~is_empty_o[v].
  - read_i[v] pops the FIFO. read_i[v] on an empty FIFO is ignored and sets error.
  - Same write rules as VA.
  - Error on vc_valid_i[v].
  - Popping TAIL/HEADTAIL -> IDLE; clear end_packet; vc_allocatable_o[v] pulses the next cycle.
- Illegal state encoding: -> IDLE, error, vc_allocatable pulse.

Flow control:
- credit_o[v] is registered: high the cycle after each successful pop.
- on_off_o[v] is registered from the post-update count: 0 when BUFFER_SIZE - count <= OFF_THRESH.

Errors:
- error_o[v] is registered, appearing the cycle after the offending event.
- Errors of different VCs are independent.

Optional Feature:
Macro INBUF_ERR_STICKY_EN.
- Defined: error_o[v] is sticky; it stays 1 until rst.
- Undefined: error_o[v] is a one-cycle pulse per offending cycle.

Test Plan:
- VC1: HEAD(out_port_i=EAST), BODY, TAIL on consecutive cycles -> vc_request_o[1] = 1 from cycle 1. Then vc_valid_i[1] = 1 with vc_new_i = 0 -> switch_request_o[1] = 1. Three pops -> credit_o[1] pulses 3 times, each lagging its pop by one cycle; vc_allocatable_o[1] pulse after the TAIL pop; VC0 untouched.
- Interleaved HEAD to VC0 and VC1 on alternate cycles -> both FSMs reach VA independently; data_o[v].vc_id equals the granted id after SA.
- BUFFER_SIZE=8, OFF_THRESH=2: write 6 flits without a pop -> on_off_o = 0 after the 6th; 8 flits -> is_full_o = 1; 9th write dropped, error_o = 1; 9th write with a simultaneous pop -> accepted, count stays 8.
- BODY to an IDLE VC, and read_i on an empty SA VC -> error_o pulse; state unchanged. Repeat with INBUF_ERR_STICKY_EN -> error_o held until rst.
- rst asserted in SA with 4 buffered flits -> next cycle: IDLE, is_empty_o = 1, on_off_o = 1, no credit_o pulse.
- HEADTAIL write then pop -> single-flit packet returns VC to IDLE; vc_allocatable_o pulses once.

Source files
------------

// File: rtl/vc_input_buffer_bank.sv
// Multi-VC input buffer bank: per-VC flit FIFO with an IDLE/VA/SA packet FSM, credits and on/off.
// Flit = {label[1:0], vc_id, payload}; labels HEAD=0, BODY=1, TAIL=2, HEADTAIL=3; DLA0 port id = 0.
// Optional macro INBUF_ERR_STICKY_EN makes error_o sticky until rst.
module vc_input_buffer_bank #(
  parameter int unsigned VC_NUM      = 2,
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned OFF_THRESH  = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PORT_W      = 3,
  localparam int unsigned VcW        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int unsigned FlitW      = 2 + VcW + DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FlitW-1:0]         data_i,
  input  logic                     valid_i,
  input  logic [PORT_W-1:0]        out_port_i,
  input  logic [VC_NUM-1:0]        read_i,
  input  logic [VC_NUM-1:0]        vc_valid_i,
  input  logic [VC_NUM*VcW-1:0]    vc_new_i,
  output logic [VC_NUM*FlitW-1:0]  data_o,
  output logic [VC_NUM*PORT_W-1:0] out_port_o,
  output logic [VC_NUM*VcW-1:0]    downstream_vc_o,
  output logic [VC_NUM-1:0]        vc_request_o,
  output logic [VC_NUM-1:0]        switch_request_o,
  output logic [VC_NUM-1:0]        vc_allocatable_o,
  output logic [VC_NUM-1:0]        credit_o,
  output logic [VC_NUM-1:0]        is_empty_o,
  output logic [VC_NUM-1:0]        is_full_o,
  output logic [VC_NUM-1:0]        on_off_o,
  output logic [VC_NUM-1:0]        error_o
);

  localparam int unsigned PtrW = $clog2(BUFFER_SIZE);
  localparam int unsigned CntW = PtrW + 1;
  // on_off stays high while count < BUFFER_SIZE - OFF_THRESH, i.e. free slots > OFF_THRESH
  localparam logic [CntW-1:0] OnLimit  = CntW'(BUFFER_SIZE - OFF_THRESH);
  localparam logic [CntW-1:0] FullCnt  = CntW'(BUFFER_SIZE);
  localparam logic [PORT_W-1:0] PortDla0 = '0;

  localparam logic [1:0] LblHead     = 2'd0;
  localparam logic [1:0] LblBody     = 2'd1;
  localparam logic [1:0] LblTail     = 2'd2;
  localparam logic [1:0] LblHeadTail = 2'd3;

  typedef enum logic [1:0] {StIdle = 2'b00, StVa = 2'b01, StSa = 2'b10} state_e;

  logic [1:0]     in_label;
  logic [VcW-1:0] in_vc;
  assign in_label = data_i[FlitW-1 -: 2];
  assign in_vc    = data_i[DATA_W +: VcW];

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    state_e            state_q, state_d;
    logic [FlitW-1:0]  mem_q [BUFFER_SIZE];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              end_pkt_q, end_pkt_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [VcW-1:0]    dvc_q, dvc_d;
    logic              credit_q, alloc_q, alloc_d, err_q, err_d, on_off_q, on_off_d;
    logic              sel, empty, full, wr_legal, push, pop, err, vc_req, sw_req;
    logic [FlitW-1:0]  head;
    logic [1:0]        head_label;
    logic              unused_head_vc;

    assign sel            = valid_i && (in_vc == VcW'(v));
    assign empty          = (count_q == '0);
    assign full           = (count_q == FullCnt);
    assign head           = mem_q[rd_ptr_q];
    assign head_label     = head[FlitW-1 -: 2];
    assign unused_head_vc = ^head[DATA_W +: VcW];

    always_comb begin
      state_d   = state_q;
      end_pkt_d = end_pkt_q;
      port_d    = port_q;
      dvc_d     = dvc_q;
      alloc_d   = 1'b0;
      wr_legal  = 1'b0;
      pop       = 1'b0;
      err       = 1'b0;
      vc_req    = 1'b0;
      sw_req    = 1'b0;
      case (state_q)
        StIdle: begin
          if (sel) begin
            if ((in_label == LblHead || in_label == LblHeadTail) && empty) begin
              wr_legal  = 1'b1;
              state_d   = StVa;
              port_d    = out_port_i;
              end_pkt_d = (in_label == LblHeadTail);
            end else begin
              err = 1'b1;
            end
          end
          if (read_i[v] || vc_valid_i[v] || !empty) err = 1'b1;
        end
        StVa, StSa: begin
          if (sel) begin
            if ((in_label == LblBody || in_label == LblTail) && !end_pkt_q) wr_legal = 1'b1;
            else err = 1'b1;
          end
          if (state_q == StVa) begin
            vc_req = 1'b1;
            if (read_i[v]) err = 1'b1;
            if (vc_valid_i[v]) begin
              state_d = StSa;
              dvc_d   = vc_new_i[v*VcW +: VcW];
            end
          end else begin
            sw_req = !empty;
            if (vc_valid_i[v]) err = 1'b1;
            if (read_i[v]) begin
              if (empty) begin
                err = 1'b1;
              end else begin
                pop = 1'b1;
                if (head_label == LblTail || head_label == LblHeadTail) begin
                  state_d   = StIdle;
                  end_pkt_d = 1'b0;
                  alloc_d   = 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
          err     = 1'b1;
          alloc_d = 1'b1;
        end
      endcase
      // A full FIFO still accepts a write when the same cycle pops a flit
      push = wr_legal && (!full || pop);
      if (wr_legal && !push) err = 1'b1;
      if (push && in_label == LblTail) end_pkt_d = 1'b1;
      count_d  = count_q + CntW'(push) - CntW'(pop);
      on_off_d = (count_d < OnLimit);
`ifdef INBUF_ERR_STICKY_EN
      err_d = err_q | err;
`else
      err_d = err;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= StIdle;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        end_pkt_q <= 1'b0;
        port_q    <= PortDla0;
        dvc_q     <= '0;
        credit_q  <= 1'b0;
        alloc_q   <= 1'b0;
        err_q     <= 1'b0;
        on_off_q  <= 1'b1;
      end else begin
        state_q   <= state_d;
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q   <= count_d;
        end_pkt_q <= end_pkt_d;
        port_q    <= port_d;
        dvc_q     <= dvc_d;
        credit_q  <= pop;
        alloc_q   <= alloc_d;
        err_q     <= err_d;
        on_off_q  <= on_off_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o[v*FlitW +: FlitW]       = {head_label, dvc_q, head[DATA_W-1:0]};
    assign out_port_o[v*PORT_W +: PORT_W] = port_q;
    assign downstream_vc_o[v*VcW +: VcW]  = dvc_q;
    assign vc_request_o[v]                = vc_req;
    assign switch_request_o[v]            = sw_req;
    assign vc_allocatable_o[v]            = alloc_q;
    assign credit_o[v]                    = credit_q;
    assign is_empty_o[v]                  = empty;
    assign is_full_o[v]                   = full;
    assign on_off_o[v]                    = on_off_q;
    assign error_o[v]                     = err_q;
  end

endmodule
